// File: rtl/nf10_axil_master.sv
// nf10_axil_master: AXI4-Lite master engine.
// A single-beat command/response handshake is turned into one AXI4-Lite read
// or write transaction, with at most one transaction outstanding. A
// saturating response timer abandons transactions to hung slaves.
module nf10_axil_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_TIMEOUT_CYCLES   = 1024
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   // command / response side
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_rnw,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic                              rsp_timeout,
   // AXI4-Lite master
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   // Timer is wide enough to hold C_TIMEOUT_CYCLES; at least one bit when disabled.
   localparam int TW = (C_TIMEOUT_CYCLES > 0) ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'((C_TIMEOUT_CYCLES > 0) ? C_TIMEOUT_CYCLES - 1 : 0);
   localparam logic [TW-1:0] TIMER_MAX  = '1;

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

   state_t                            state_reg;
   logic [TW-1:0]                     timer_reg;
   logic                              aw_done_reg, w_done_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr_reg, araddr_reg;
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_reg, rdata_reg;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_reg;
   logic                              awvalid_reg, wvalid_reg, bready_reg, arvalid_reg, rready_reg;
   logic                              rsp_valid_reg, rsp_timeout_reg;
   logic [1:0]                        rsp_resp_reg;

   logic aw_hs, w_hs, aw_done_next, w_done_next;
   logic in_txn, expire, done_now, abort;

   assign aw_hs        = awvalid_reg && M_AXI_AWREADY;
   assign w_hs         = wvalid_reg  && M_AXI_WREADY;
   assign aw_done_next = aw_done_reg || aw_hs;
   assign w_done_next  = w_done_reg  || w_hs;
   assign in_txn       = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                         (state_reg == RD_REQ) || (state_reg == RD_RESP);
   assign expire       = (C_TIMEOUT_CYCLES != 0) && (timer_reg == TIMER_LAST);
   assign abort        = in_txn && expire && !done_now;

   // Detect the handshake that ends the current wait state; it beats the timeout.
   always_comb begin
      done_now = 1'b0;
      case (state_reg)
         WR_REQ:  done_now = aw_done_next && w_done_next;
         WR_RESP: done_now = bready_reg && M_AXI_BVALID;
         RD_REQ:  done_now = arvalid_reg && M_AXI_ARREADY;
         RD_RESP: done_now = rready_reg && M_AXI_RVALID;
         default: done_now = 1'b0;
      endcase
   end

   // Transaction FSM with registered AXI and response outputs plus the response timer.
   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         state_reg       <= IDLE;
         timer_reg       <= '0;
         aw_done_reg     <= 1'b0;
         w_done_reg      <= 1'b0;
         awaddr_reg      <= '0;
         araddr_reg      <= '0;
         wdata_reg       <= '0;
         wstrb_reg       <= '0;
         awvalid_reg     <= 1'b0;
         wvalid_reg      <= 1'b0;
         bready_reg      <= 1'b0;
         arvalid_reg     <= 1'b0;
         rready_reg      <= 1'b0;
         rsp_valid_reg   <= 1'b0;
         rsp_timeout_reg <= 1'b0;
         rsp_resp_reg    <= 2'b00;
         rdata_reg       <= '0;
      end else begin
         if (in_txn && timer_reg != TIMER_MAX)
            timer_reg <= timer_reg + 1'b1;
         case (state_reg)
            IDLE: begin
               if (cmd_valid) begin
                  timer_reg   <= '0;
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
                  if (cmd_rnw) begin
                     araddr_reg  <= cmd_addr;
                     arvalid_reg <= 1'b1;
                     state_reg   <= RD_REQ;
                  end else begin
                     awaddr_reg  <= cmd_addr;
                     wdata_reg   <= cmd_wdata;
                     wstrb_reg   <= cmd_wstrb;
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               aw_done_reg <= aw_done_next;
               w_done_reg  <= w_done_next;
               if (aw_hs) awvalid_reg <= 1'b0;
               if (w_hs)  wvalid_reg  <= 1'b0;
               if (aw_done_next && w_done_next) begin
                  bready_reg <= 1'b1;
                  state_reg  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (M_AXI_BVALID) begin
                  bready_reg      <= 1'b0;
                  rsp_resp_reg    <= M_AXI_BRESP;
                  rdata_reg       <= '0;
                  rsp_timeout_reg <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  state_reg       <= RSP;
               end
            end
            RD_REQ: begin
               if (M_AXI_ARREADY) begin
                  arvalid_reg <= 1'b0;
                  rready_reg  <= 1'b1;
                  state_reg   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (M_AXI_RVALID) begin
                  rready_reg      <= 1'b0;
                  rdata_reg       <= M_AXI_RDATA;
                  rsp_resp_reg    <= M_AXI_RRESP;
                  rsp_timeout_reg <= 1'b0;
                  rsp_valid_reg   <= 1'b1;
                  state_reg       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
         // Hung slave: abandon the transaction; late beats are ignored since READY drops.
         if (abort) begin
            awvalid_reg     <= 1'b0;
            wvalid_reg      <= 1'b0;
            bready_reg      <= 1'b0;
            arvalid_reg     <= 1'b0;
            rready_reg      <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_timeout_reg <= 1'b1;
            rsp_resp_reg    <= 2'b10;
            rdata_reg       <= '0;
            state_reg       <= RSP;
         end
      end
   end

   assign cmd_ready     = (state_reg == IDLE);
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_rdata     = rdata_reg;
   assign rsp_resp      = rsp_resp_reg;
   assign rsp_timeout   = rsp_timeout_reg;
   assign M_AXI_AWADDR  = awaddr_reg;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_reg;
   assign M_AXI_WDATA   = wdata_reg;
   assign M_AXI_WSTRB   = wstrb_reg;
   assign M_AXI_WVALID  = wvalid_reg;
   assign M_AXI_BREADY  = bready_reg;
   assign M_AXI_ARADDR  = araddr_reg;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_reg;
   assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_nf10_axil_master.sv
// Directed bench for nf10_axil_master: the AXI slave side is driven by hand,
// inputs change and outputs are sampled on the falling clock edge.
module tb_nf10_axil_master;
   logic        clk = 1'b0;
   logic        resetn;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   nf10_axil_master #(
      .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32), .C_TIMEOUT_CYCLES(16)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
      .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-22s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic send(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
   endtask

   initial begin
      resetn = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      bresp = 2'b00; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      step(); step(); step();

      // ---- reset values
      chk("rst_awvalid", awvalid, 0);   chk("rst_wvalid", wvalid, 0);
      chk("rst_arvalid", arvalid, 0);   chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);     chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0); chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);     chk("rst_awaddr", awaddr, 0);
      chk("rst_wdata", wdata, 0);       chk("rst_wstrb", wstrb, 0);
      chk("rst_araddr", araddr, 0);     chk("rst_prot", {awprot, arprot}, 0);
      resetn = 1'b1;
      step();
      chk("rst_cmd_ready", cmd_ready, 1);

      // ---- zero-wait write
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      send(1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
      step();                                       // T+1
      cmd_valid = 1'b0;
      chk("zw_awvalid_t1", awvalid, 1); chk("zw_wvalid_t1", wvalid, 1);
      chk("zw_awaddr", awaddr, 32'h40); chk("zw_wdata", wdata, 32'hDEADBEEF);
      chk("zw_wstrb", wstrb, 4'hF);     chk("zw_cmd_ready_t1", cmd_ready, 0);
      step();                                       // T+2
      chk("zw_bready_t2", bready, 1);   chk("zw_awvalid_t2", awvalid, 0);
      chk("zw_wvalid_t2", wvalid, 0);   chk("zw_rsp_valid_t2", rsp_valid, 0);
      step();                                       // T+3
      chk("zw_rsp_valid_t3", rsp_valid, 1); chk("zw_rsp_resp", rsp_resp, 0);
      chk("zw_rsp_rdata", rsp_rdata, 0);    chk("zw_rsp_timeout", rsp_timeout, 0);
      chk("zw_bready_t3", bready, 0);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("zw_rsp_valid_done", rsp_valid, 0); chk("zw_cmd_ready_done", cmd_ready, 1);

      // ---- read with delays, then response back-pressure
      send(1'b1, 32'h0000_0010, 32'h0, 4'h0);
      step();                                       // T+1
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("rd_arvalid_wait", arvalid, 1);
         chk("rd_araddr_wait", araddr, 32'h10);
         step();
      end
      arready = 1'b1;                               // T+4
      chk("rd_arvalid_hs", arvalid, 1);
      step();                                       // T+5
      arready = 1'b0;
      chk("rd_arvalid_drop", arvalid, 0); chk("rd_rready", rready, 1);
      step();                                       // T+6
      rvalid = 1'b1; rdata = 32'h4E46_3130; rresp = 2'b00;
      chk("rd_rsp_valid_early", rsp_valid, 0);
      step();                                       // T+7
      rvalid = 1'b0; rdata = 32'h0;
      chk("rd_rsp_valid", rsp_valid, 1); chk("rd_rsp_rdata", rsp_rdata, 32'h4E463130);
      chk("rd_rsp_resp", rsp_resp, 0);   chk("rd_rsp_timeout", rsp_timeout, 0);
      chk("rd_rready_drop", rready, 0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h4E463130);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rd_cmd_ready_done", cmd_ready, 1);

      // ---- skewed write channels, BRESP pass-through
      send(1'b0, 32'h0000_0044, 32'h1234_5678, 4'h3);
      step();                                       // T+1
      cmd_valid = 1'b0; wready = 1'b1;
      chk("sk_awvalid_t1", awvalid, 1); chk("sk_wvalid_t1", wvalid, 1);
      step();                                       // T+2
      wready = 1'b0;
      chk("sk_wvalid_drop", wvalid, 0); chk("sk_awvalid_held", awvalid, 1);
      chk("sk_bready_early", bready, 0);
      step(); step();                               // T+4
      chk("sk_awvalid_t4", awvalid, 1); chk("sk_awaddr_stable", awaddr, 32'h44);
      chk("sk_wvalid_t4", wvalid, 0);   chk("sk_bready_t4", bready, 0);
      step();                                       // T+5
      awready = 1'b1;
      step();                                       // T+6
      awready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
      chk("sk_awvalid_drop", awvalid, 0); chk("sk_bready", bready, 1);
      step();                                       // T+7
      bvalid = 1'b0; bresp = 2'b00;
      chk("sk_rsp_valid", rsp_valid, 1); chk("sk_rsp_resp", rsp_resp, 2'b10);
      chk("sk_rsp_rdata", rsp_rdata, 0); chk("sk_rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // ---- read timeout (16 cycles), late R beat ignored
      send(1'b1, 32'h0000_0080, 32'h0, 4'h0);
      step();                                       // T+1
      cmd_valid = 1'b0;
      for (int i = 1; i < 16; i++) step();          // T+16, expiry cycle
      chk("to_arvalid_last", arvalid, 1); chk("to_rsp_valid_last", rsp_valid, 0);
      step();                                       // T+17
      chk("to_arvalid_drop", arvalid, 0);  chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_resp", rsp_resp, 2'b10); chk("to_rsp_timeout", rsp_timeout, 1);
      chk("to_rsp_rdata", rsp_rdata, 0);   chk("to_rready", rready, 0);
      rvalid = 1'b1; rdata = 32'h0BAD_BAD0; rresp = 2'b00;
      step(); step();
      chk("to_late_rready", rready, 0); chk("to_late_rdata", rsp_rdata, 0);
      chk("to_late_resp", rsp_resp, 2'b10);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("to_late_rsp_valid", rsp_valid, 0); chk("to_cmd_ready", cmd_ready, 1);
      step();
      chk("to_late_idle", rsp_valid, 0);

      // ---- zero-wait read after timeout clears rsp_timeout
      arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b01;
      send(1'b1, 32'h0000_0004, 32'h0, 4'h0);
      step();                                       // T+1
      cmd_valid = 1'b0;
      chk("zr_arvalid_t1", arvalid, 1);
      step();                                       // T+2
      chk("zr_rready_t2", rready, 1);
      step();                                       // T+3
      arready = 1'b0; rvalid = 1'b0;
      chk("zr_rsp_valid", rsp_valid, 1); chk("zr_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("zr_rsp_resp", rsp_resp, 2'b01); chk("zr_rsp_timeout", rsp_timeout, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      // ---- reset during WR_REQ
      send(1'b0, 32'h0000_0048, 32'h5555_AAAA, 4'hC);
      step();                                       // T+1
      cmd_valid = 1'b0;
      chk("mr_awvalid_before", awvalid, 1);
      resetn = 1'b0;
      step();
      chk("mr_awvalid", awvalid, 0); chk("mr_wvalid", wvalid, 0);
      chk("mr_bready", bready, 0);   chk("mr_awaddr", awaddr, 0);
      chk("mr_wdata", wdata, 0);     chk("mr_wstrb", wstrb, 0);
      chk("mr_rsp_valid", rsp_valid, 0); chk("mr_cmd_ready", cmd_ready, 1);
      resetn = 1'b1;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mr_no_rsp", rsp_valid, 0);
         chk("mr_no_awvalid", awvalid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/nf10_axil_master.md
# nf10_axil_master

AXI4-Lite master engine that turns a single-beat command/response handshake into AXI4-Lite read and write transactions. It is the initiator-side counterpart of the register-mapped slaves on the control interconnect, such as identifier ROMs and stats blocks. It serves on-chip agents that must read or program registers without a host, for example a boot-time identifier scanner or a self-test sequencer. It supports one outstanding transaction and has a configurable response timeout.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_TIMEOUT_CYCLES, 1024, maximum cycles a transaction may wait on the slave; 0 disables the timeout.

Clock, reset and command side:
- M_AXI_ACLK  in  1  single clock for everything.
- M_AXI_ARESETN  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA  read data; 0 for writes and timeouts.
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  transaction was abandoned by the timeout.

AXI4-Lite master ports (standard):
- M_AXI_AWADDR  out  ADDR
- M_AXI_AWPROT  out  3  tied 0.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DATA
- M_AXI_WSTRB  out  DATA/8
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR
- M_AXI_ARPROT  out  3  tied 0.
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

## Operation
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP. All outputs are registered except cmd_ready, which equals (state == IDLE).
- **IDLE:**
  - On command handshake, latch addr, wdata and wstrb onto the AXI address/data outputs.
  - A write goes to WR_REQ with AWVALID = WVALID = 1; a read goes to RD_REQ with ARVALID = 1.
- **WR_REQ:**
  - AW and W handshakes complete independently. Each VALID drops on the edge after its own handshake; flags aw_done and w_done record completion.
  - A simultaneous AW and W handshake completes both in the same cycle.
  - When both are done, assert BREADY and go to WR_RESP.
- **WR_RESP:** on BVALID && BREADY, capture BRESP, drop BREADY, set rsp_rdata = 0, and go to RSP.
- **RD_REQ:** on ARREADY, drop ARVALID, assert RREADY, and go to RD_RESP.
- **RD_RESP:** on RVALID && RREADY, capture RDATA and RRESP, drop RREADY, and go to RSP.
- **RSP:** hold rsp_valid = 1 with stable data until rsp_ready, then go to IDLE. cmd_ready rises the cycle after the response is consumed.
- **Timeout counter:**
  - Cleared on command accept; increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches C_TIMEOUT_CYCLES−1 with no terminating handshake that cycle:
    - all AXI VALID and READY outputs drop on the next edge;
    - rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0;
    - the FSM goes to RSP.
  - A handshake in the expiry cycle wins over the timeout.
  - This is a documented recovery path for hung slaves. Any late B or R beat from the abandoned transaction is ignored, because READY is low.
- **Counter width:** clog2(C_TIMEOUT_CYCLES+1); the counter saturates and never wraps.
- **Response fields:** rsp_timeout is cleared on every normal completion.

## Timing
- **Reset values:**
  - all VALID and READY outputs = 0;
  - rsp_valid = 0, rsp_timeout = 0, rsp_resp = 0, rsp_rdata = 0;
  - AWADDR, ARADDR, WDATA and WSTRB = 0;
  - cmd_ready = 1 in the cycle after reset deasserts.
- **Reset mid-transaction:** the edge that samples ARESETN low forces IDLE and the reset values; no response is emitted.
- **Minimum write latency** (zero-wait slave; BVALID is visible in the same cycle BREADY rises):
  - accept at T;
  - AW/W handshake at T+1;
  - BREADY at T+2, B handshake at T+2;
  - rsp_valid at T+3.
- **Minimum read latency:**
  - accept at T;
  - AR handshake at T+1;
  - RREADY at T+2, R handshake at T+2;
  - rsp_valid at T+3.
- **AXI rules:**
  - VALIDs never depend combinationally on READYs.
  - Address, data and strobe are stable while their VALID is high.
- **Throughput:** one transaction per (latency + 1) cycles, at most one outstanding.

## Test plan
- **Zero-wait write:** addr 0x40, data 0xDEADBEEF, strb 0xF, slave always ready with BRESP 0 → AW/W at T+1, rsp_valid at T+3 with resp 0, rdata 0, timeout 0.
- **Read with delays:** ARREADY after 3 cycles, RVALID 2 cycles later with RDATA 0x4E463130 and RRESP 0 → rsp_rdata 0x4E463130, ARVALID stable throughout the wait.
- **Skewed write channels:** WREADY 4 cycles before AWREADY → WVALID drops after its handshake, AWVALID is held, BREADY rises only once both are done; a slave BRESP of 2'b10 is passed through to rsp_resp.
- **Timeout:** C_TIMEOUT_CYCLES = 16, slave never raises ARREADY → ARVALID drops and rsp_valid rises with resp 2'b10, timeout 1; a late RVALID after that is ignored.
- **Back-pressure and reset:** rsp_ready held low 10 cycles → rsp fields stable and cmd_ready stays 0. Assert ARESETN low during WR_REQ → all outputs at reset values the next cycle, with no response emitted.
